// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - result codes, FSM encoding and flag helper for cmp_event_tracker
package cmp_pkg;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LT   = 2'b01;
  localparam logic [1:0] RES_GT   = 2'b10;
  localparam logic [1:0] RES_EQ   = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_TRACK  = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;
  localparam logic [1:0] ST_FAULT  = 2'b11;

  // True when exactly one comparator flag is set.
  function automatic logic is_one_hot3(input logic a, input logic b, input logic c);
    return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous reset and clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/cmp_event_tracker.sv
// rtl/cmp_event_tracker.sv - registers comparator results, counts outcomes, detects EQ lock and illegal flags
module cmp_event_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  input  logic             clear,
  output logic [1:0]       result,
  output logic             result_valid,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             locked,
  output logic             fault
);

  localparam logic [3:0] LOCK_V = LOCK_N[3:0];

  logic [1:0] state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic [1:0] result_q, result_d;
  logic       rv_q, rv_d;
  logic       legal, take, accept;
  logic [3:0] streak_inc;

  assign legal      = is_one_hot3(lt, gt, eq);
  // FAULT swallows every sample; clear discards the sample of its own cycle.
  assign take       = in_valid && !clear && (state_q != ST_FAULT);
  assign accept     = take && legal;
  assign streak_inc = (streak_q == LOCK_V) ? streak_q : streak_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    result_d = result_q;
    rv_d     = 1'b0;
    if (clear) begin
      state_d  = ST_IDLE;
      streak_d = 4'd0;
      result_d = RES_NONE;
    end else if (take && !legal) begin
      state_d = ST_FAULT;
    end else if (accept) begin
      rv_d     = 1'b1;
      result_d = eq ? RES_EQ : (gt ? RES_GT : RES_LT);
      if (eq) begin
        streak_d = streak_inc;
        state_d  = (streak_inc == LOCK_V) ? ST_LOCKED : ST_TRACK;
      end else begin
        streak_d = 4'd0;
        state_d  = ST_TRACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      streak_q <= 4'd0;
      result_q <= RES_NONE;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (accept && lt),
    .count (lt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (accept && gt),
    .count (gt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (accept && eq),
    .count (eq_cnt)
  );

  assign result       = result_q;
  assign result_valid = rv_q;
  assign locked       = (state_q == ST_LOCKED);
  assign fault        = (state_q == ST_FAULT);

endmodule

// File: tb/tb_cmp_event_tracker.sv
// tb/tb_cmp_event_tracker.sv - directed and random checks of cmp_event_tracker against a reference model
module tb_cmp_event_tracker;

  localparam int LOCK_N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0, in_valid = 1'b0, lt = 1'b0, gt = 1'b0, eq = 1'b0, clear = 1'b0;

  logic [1:0] a_result, b_result;
  logic       a_rv, b_rv, a_locked, b_locked, a_fault, b_fault;
  logic [7:0] a_lt_cnt, a_gt_cnt, a_eq_cnt;
  logic [1:0] b_lt_cnt, b_gt_cnt, b_eq_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: unbounded counts, length of the current run of accepted EQs.
  int       m_lt = 0, m_gt = 0, m_eq = 0, m_run = 0;
  logic [1:0] m_res = 2'b00;
  bit       m_rv = 0, m_fault = 0;

  always #5 clk = ~clk;

  cmp_event_tracker #(.CNT_W(8), .LOCK_N(LOCK_N)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .lt(lt), .gt(gt), .eq(eq), .clear(clear),
    .result(a_result), .result_valid(a_rv), .lt_cnt(a_lt_cnt), .gt_cnt(a_gt_cnt),
    .eq_cnt(a_eq_cnt), .locked(a_locked), .fault(a_fault)
  );

  cmp_event_tracker #(.CNT_W(2), .LOCK_N(LOCK_N)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .lt(lt), .gt(gt), .eq(eq), .clear(clear),
    .result(b_result), .result_valid(b_rv), .lt_cnt(b_lt_cnt), .gt_cnt(b_gt_cnt),
    .eq_cnt(b_eq_cnt), .locked(b_locked), .fault(b_fault)
  );

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit v, input bit l, input bit g, input bit e,
                              input bit c, input bit r);
    m_rv = 0;
    if (r || c) begin
      m_lt = 0; m_gt = 0; m_eq = 0; m_run = 0; m_res = 2'b00; m_fault = 0;
    end else if (v && !m_fault) begin
      if (int'(l) + int'(g) + int'(e) == 1) begin
        m_rv = 1;
        if (l) begin m_lt++; m_res = 2'b01; m_run = 0; end
        if (g) begin m_gt++; m_res = 2'b10; m_run = 0; end
        if (e) begin m_eq++; m_res = 2'b11; m_run++; end
      end else begin
        m_fault = 1;
      end
    end
  endtask

  task automatic check_all();
    bit exp_locked;
    exp_locked = !m_fault && (m_run >= LOCK_N);
    chk("a_result", a_result, m_res);
    chk("a_result_valid", a_rv, m_rv);
    chk("a_lt_cnt", a_lt_cnt, sat(m_lt, 8));
    chk("a_gt_cnt", a_gt_cnt, sat(m_gt, 8));
    chk("a_eq_cnt", a_eq_cnt, sat(m_eq, 8));
    chk("a_locked", a_locked, exp_locked);
    chk("a_fault", a_fault, m_fault);
    chk("b_result", b_result, m_res);
    chk("b_result_valid", b_rv, m_rv);
    chk("b_lt_cnt", b_lt_cnt, sat(m_lt, 2));
    chk("b_gt_cnt", b_gt_cnt, sat(m_gt, 2));
    chk("b_eq_cnt", b_eq_cnt, sat(m_eq, 2));
    chk("b_locked", b_locked, exp_locked);
    chk("b_fault", b_fault, m_fault);
  endtask

  task automatic step(input bit v, input bit l, input bit g, input bit e,
                      input bit c, input bit r);
    in_valid = v; lt = l; gt = g; eq = e; clear = c; reset = r;
    @(posedge clk);
    model_update(v, l, g, e, c, r);
    #1;
    check_all();
  endtask

  initial begin
    // reset, GT, LT
    step(0, 0, 0, 0, 0, 1);
    chk("reset_result", a_result, 2'b00);
    chk("reset_locked", a_locked, 1'b0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    // four EQs with a gap, then GT breaks the lock
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("not_yet_locked", a_locked, 1'b0);
    step(1, 0, 0, 1, 0, 0);
    chk("locked_after_4th", a_locked, 1'b1);
    step(1, 0, 1, 0, 0, 0);
    chk("unlocked_after_gt", a_locked, 1'b0);
    // illegal lt+gt, later samples ignored, clear
    step(1, 1, 1, 0, 0, 0);
    chk("fault_lt_gt", a_fault, 1'b1);
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("clear_exits_fault", a_fault, 1'b0);
    // illegal all-zero
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("fault_zero_flags", a_fault, 1'b1);
    step(0, 0, 0, 0, 1, 0);
    // five EQs: narrow counters saturate at 3
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 0);
    chk("b_eq_sat", b_eq_cnt, 2'd3);
    // clear with a simultaneous EQ discards the sample
    step(1, 0, 0, 1, 1, 0);
    chk("clear_eq_discard", a_eq_cnt, 8'd0);
    // reset while locked
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 0);
    chk("locked_before_reset", a_locked, 1'b1);
    step(1, 0, 0, 1, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      int k;
      bit v, l, g, e, c, r;
      logic [2:0] f;
      logic [2:0] bad [5];
      bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
      v = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 99);
      if (k < 92) begin
        case ($urandom_range(0, 5))
          0:       f = 3'b100;
          1:       f = 3'b010;
          default: f = 3'b001;
        endcase
      end else begin
        f = bad[$urandom_range(0, 4)];
      end
      l = f[2]; g = f[1]; e = f[0];
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 149) == 0);
      step(v, l, g, e, c, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_event_tracker.md
# cmp_event_tracker

Sequential stage directly downstream of the 2-bit magnitude comparator. It samples the comparator's one-hot less/greater/equal flags under a valid strobe and registers the last legal result. It keeps a saturating count of each outcome, raises a lock indication after a run of consecutive equal results, and traps illegal flag combinations in a sticky fault state. Downstream control logic reads `locked`, `fault` and the counters.

## Interface
One clock; reset is synchronous and active-high.

Parameters:
- `CNT_W`, default 8: width of each outcome counter.
- `LOCK_N`, default 4, legal range 2..15: number of consecutive accepted equal samples required to lock.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-high; returns every register to its reset value.
- `in_valid`, in, 1: comparator flags are valid this cycle.
- `lt`, in, 1: comparator "A less than B" flag.
- `gt`, in, 1: comparator "A greater than B" flag.
- `eq`, in, 1: comparator "A equal to B" flag.
- `clear`, in, 1: synchronous soft clear of counters, streak, result and state.
- `result`, out, 2: last legal result; 00 = none, 01 = LT, 10 = GT, 11 = EQ.
- `result_valid`, out, 1: one-cycle pulse, high the cycle after a legal sample is accepted.
- `lt_cnt`, out, CNT_W: saturating count of accepted LT samples.
- `gt_cnt`, out, CNT_W: saturating count of accepted GT samples.
- `eq_cnt`, out, CNT_W: saturating count of accepted EQ samples.
- `locked`, out, 1: high while in LOCKED.
- `fault`, out, 1: high while in FAULT.

## Operation
- Legal sample: `in_valid`=1 and exactly one of `lt`/`gt`/`eq` is high.
- Illegal sample: `in_valid`=1 and zero or two or more flags are high.
- Samples with `in_valid`=0 are ignored. Gaps do not break a streak.
- Accepting a legal sample does three things:
  - updates `result`;
  - increments the matching counter, which saturates at 2^CNT_W-1 and never wraps;
  - pulses `result_valid`.
- Streak register, 4 bits: EQ increments it, saturating at LOCK_N; LT or GT zeroes it.
- FSM states: IDLE, TRACK, LOCKED, FAULT. Reset state is IDLE.
  - IDLE: a legal sample moves to TRACK, with streak = 1 if EQ, else 0.
  - TRACK: EQ moves to LOCKED when the incremented streak equals LOCK_N. LT or GT stays in TRACK with streak 0.
  - LOCKED: EQ stays in LOCKED. LT or GT moves to TRACK with streak 0.
  - Any state other than FAULT: an illegal sample moves to FAULT. Counters, `result` and streak are frozen at their prior values, and `result_valid` stays low.
  - FAULT: all samples are ignored. Only `clear` or `reset` exits, to IDLE.
- `clear` has priority over `in_valid` in the same cycle; that sample is discarded. `clear` zeroes the counters, streak and `result`, and returns to IDLE.
- `reset` has priority over everything. It may occur mid-run; the next cycle shows all reset values.

## Timing
- All outputs are registered. Latency from the accepted sample edge to visible outputs is 1 cycle.
- Reset values: `result`=00, `result_valid`=0, all counters 0, `locked`=0, `fault`=0, state IDLE, streak 0.
- `locked` rises the cycle after the LOCK_N-th consecutive accepted EQ. It falls the cycle after the first accepted LT or GT.
- `fault` rises the cycle after an illegal sample and stays high until the cycle after `clear` or `reset`.
- The block accepts one sample per cycle back-to-back. There is no backpressure.
- Saturated counters hold their value. Further same-type samples still update `result` and pulse `result_valid`.

## Structure
- Shared package `cmp_pkg` holds:
  - result code constants: RES_NONE, RES_LT, RES_GT, RES_EQ;
  - the 2-bit FSM state encoding: ST_IDLE, ST_TRACK, ST_LOCKED, ST_FAULT.
- Sub-module `sat_counter`, parameterised by width, with synchronous reset, clear and increment inputs. It is instantiated three times, for LT, GT and EQ.
- FSM, streak register and legality check live in the top module.

## Test plan
- Reset, then one legal GT then one legal LT sample -> `result`=10 then 01; `gt_cnt`=1, `lt_cnt`=1; `result_valid` pulses twice; state TRACK; `locked`=0.
- Four consecutive EQ samples (LOCK_N=4), with one `in_valid`=0 gap cycle after the second -> `locked`=1 the cycle after the 4th EQ; `eq_cnt`=4. A following GT sample -> `locked`=0 the next cycle.
- Illegal samples, `lt`=`gt`=1 and separately all-zero with `in_valid`=1 -> `fault`=1 the next cycle; counters frozen. Later legal samples have no effect. `clear` -> IDLE, counters 0, `fault`=0.
- CNT_W=2 with five EQ samples -> `eq_cnt` reaches 3 and holds at 3; `result_valid` pulses five times.
- `clear` and a legal EQ sample in the same cycle -> sample discarded; `eq_cnt`=0, `result`=00, `result_valid`=0.
- `reset` asserted while LOCKED -> next cycle all outputs equal their reset values, state IDLE.
